exec_mem_pipe: RTL
==================

Name: exec_mem_pipe

Overview:
Parametrised, handshaked successor to the fixed EX/MEM pipeline register. It carries an opaque EX-stage payload plus a separate memory-write-enable bit into the MEM stage. It adds valid/ready flow control, an optional skid buffer for full throughput with a registered ready, synchronous flush that kills in-flight side effects, and saturating stall/flush counters. It sits between the execute and memory stages of the pipelined core.

Parameters:
DATA_W, 70, payload width (pc_inc 16 + bs 16 + alu 16 + m8_sel 2 + m2 3 + mem_wr_data 16 + spare 1).
SKID, 1, 0 = single register with combinational ready pass-through; 1 = main register plus skid register with registered in_ready.
CNT_W, 16, width of the stall and flush performance counters.

Ports:
clk  input  1  sole clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  EX stage presents a transfer.
in_ready  output  1  stage can accept; transfer occurs when in_valid & in_ready at the clk edge.
in_data  input  DATA_W  EX payload.
in_wr_en  input  1  memory write enable accompanying the payload.
out_valid  output  1  MEM-side entry valid.
out_ready  input  1  MEM stage consumes; transfer occurs when out_valid & out_ready.
out_data  output  DATA_W  payload of the head entry.
out_wr_en  output  1  head entry's write enable, gated by out_valid.
flush  input  1  synchronous kill of all held entries.
occupancy  output  2  number of valid entries held (0..2; max 1 when SKID=0).
clr_cnt  input  1  synchronous clear of both counters.
stall_cnt  output  CNT_W  cycles with out_valid & ~out_ready.
flush_cnt  output  CNT_W  flush cycles that killed at least one valid entry.

Behaviour:
- Reset (async, any time, including mid-transfer): all valid flags 0, out_data 0, out_wr_en 0, occupancy 0, both counters 0. in_ready = 1 once rst deasserts (SKID=1: registered ready resets to 1).
- out_wr_en = out_valid & stored wr_en. It is never 1 when out_valid = 0.
- While out_valid & ~out_ready, out_data and out_wr_en are held stable.
- Latency: an accepted input appears on out_valid/out_data on the next rising edge (1 cycle), in both modes.
- SKID=0: in_ready = ~out_valid | out_ready (combinational). Main register loads on accept. It clears valid when consumed with no new accept.
- SKID=1: states EMPTY (occ 0), ONE (main valid), TWO (main + skid valid). in_ready = registered ~skid_valid.
  - EMPTY + accept -> ONE.
  - ONE + accept + consume -> ONE (main reloads).
  - ONE + accept & ~consume -> TWO (data goes to skid).
  - ONE + consume only -> EMPTY.
  - TWO + consume -> ONE (skid moves to main). in_ready is 0 in TWO, so no accept occurs there.
  - ONE is the only state where simultaneous accept and consume occurs; main takes the new data and the skid stays empty.
- Output ordering is strict FIFO. No entry is duplicated or dropped except by flush.
- flush (priority below rst, above all handshakes): at the edge, all valid flags clear and occupancy becomes 0.
  - Any input accepted in the same cycle is discarded. in_ready is unaffected in the flush cycle.
  - A consume in the flush cycle still counts as delivered to MEM.
  - In the cycle after flush, out_valid = 0 and out_wr_en = 0.
- stall_cnt: +1 each cycle out_valid & ~out_ready; saturates at 2^CNT_W-1.
- flush_cnt: +1 each cycle flush & (occupancy != 0); saturates.
- clr_cnt wins over a simultaneous increment (counter becomes 0). Counters are not cleared by flush.
- in_data, in_wr_en are ignored when in_valid = 0. out_data is don't-care-stable (holds last value) when out_valid = 0.

Test Plan:
- Reset mid-stream: SKID=1, occupancy 2 with payloads 0xA5, 0x5A, assert rst asynchronously between edges -> out_valid, out_wr_en, occupancy, counters drop to 0 immediately; in_ready = 1 after release.
- Full throughput: SKID=1, out_ready=1, in_valid=1 for 8 cycles with data 1..8 -> out_data 1..8 on consecutive cycles starting 1 cycle after the first accept; stall_cnt = 0.
- Backpressure: SKID=1, send 0x11, 0x22, 0x33 with out_ready=0 -> 0x11 in main, 0x22 in skid, in_ready = 0, 0x33 held by the source. After releasing out_ready, the order is 0x11, 0x22, 0x33; stall_cnt = number of stalled cycles (e.g. 4).
- Flush kills writes: entry with in_wr_en=1, out_ready=0, assert flush one cycle -> next cycle out_valid=0, out_wr_en=0, flush_cnt=1. A flush with occupancy 0 leaves flush_cnt unchanged.
- SKID=0 pass-through: out_ready toggling 1,0,1 -> in_ready tracks ~out_valid | out_ready in the same cycle; occupancy never exceeds 1; data order preserved.
- Counter saturation/clear: CNT_W=3, hold a stall for 10 cycles -> stall_cnt sticks at 7. Assert clr_cnt during a stall -> 0 on the next cycle, then resumes counting.

Source files
------------

// File: rtl/exec_mem_pipe_if.sv
// Handshake bundle between the EX stage, the EX/MEM pipe and the MEM stage.
// slave is the pipe's view; master is the surrounding stages' view.
interface exec_mem_pipe_if #(
  parameter int unsigned DATA_W = 70
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_wr_en;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_wr_en;

  modport slave (
    input  in_valid, in_data, in_wr_en, out_ready,
    output in_ready, out_valid, out_data, out_wr_en
  );

  modport master (
    output in_valid, in_data, in_wr_en, out_ready,
    input  in_ready, out_valid, out_data, out_wr_en
  );
endinterface

// File: rtl/exec_mem_pipe.sv
// Handshaked EX/MEM pipeline register with optional skid buffer, synchronous
// flush and saturating stall/flush performance counters.
module exec_mem_pipe #(
  parameter int unsigned DATA_W = 70,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  exec_mem_pipe_if.slave     bus,
  input  logic               flush,
  output logic [1:0]         occupancy,
  input  logic               clr_cnt,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic              accept;
  logic              consume;
  logic              head_valid;
  logic              head_wr;
  logic [DATA_W-1:0] head_data;

  assign accept        = bus.in_valid & bus.in_ready;
  assign consume       = head_valid & bus.out_ready;
  assign bus.out_valid = head_valid;
  assign bus.out_data  = head_data;
  assign bus.out_wr_en = head_valid & head_wr;

  generate
    if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;

      state_e            state_q, state_d;
      logic              ready_q;
      logic [DATA_W-1:0] main_data_q, skid_data_q;
      logic              main_wr_q, skid_wr_q;

      always_comb begin
        state_d = state_q;
        if (flush) begin
          state_d = EMPTY;
        end else begin
          case (state_q)
            EMPTY:   if (accept) state_d = ONE;
            ONE: begin
              if (accept && !consume)      state_d = TWO;
              else if (!accept && consume) state_d = EMPTY;
            end
            TWO:     if (consume) state_d = ONE;
            default: state_d = EMPTY;
          endcase
        end
      end

      // Ready is registered from the next state so it never depends on out_ready.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state_q     <= EMPTY;
          ready_q     <= 1'b1;
          main_data_q <= '0;
          skid_data_q <= '0;
          main_wr_q   <= 1'b0;
          skid_wr_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          ready_q <= (state_d != TWO);
          if (!flush) begin
            case (state_q)
              EMPTY: if (accept) begin
                main_data_q <= bus.in_data;
                main_wr_q   <= bus.in_wr_en;
              end
              ONE: if (accept && consume) begin
                main_data_q <= bus.in_data;
                main_wr_q   <= bus.in_wr_en;
              end else if (accept) begin
                skid_data_q <= bus.in_data;
                skid_wr_q   <= bus.in_wr_en;
              end
              TWO: if (consume) begin
                main_data_q <= skid_data_q;
                main_wr_q   <= skid_wr_q;
              end
              default: ;
            endcase
          end
        end
      end

      assign bus.in_ready = ready_q;
      assign head_valid   = (state_q != EMPTY);
      assign head_data    = main_data_q;
      assign head_wr      = main_wr_q;
      assign occupancy    = (state_q == TWO) ? 2'd2 : (state_q == ONE) ? 2'd1 : 2'd0;
    end else begin : g_reg
      logic              valid_q;
      logic [DATA_W-1:0] data_q;
      logic              wr_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= 1'b0;
          data_q  <= '0;
          wr_q    <= 1'b0;
        end else if (flush) begin
          valid_q <= 1'b0;
        end else if (accept) begin
          valid_q <= 1'b1;
          data_q  <= bus.in_data;
          wr_q    <= bus.in_wr_en;
        end else if (consume) begin
          valid_q <= 1'b0;
        end
      end

      assign bus.in_ready = ~valid_q | bus.out_ready;
      assign head_valid   = valid_q;
      assign head_data    = data_q;
      assign head_wr      = wr_q;
      assign occupancy    = {1'b0, valid_q};
    end
  endgenerate

  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_inc, flush_inc;

  assign stall_inc = head_valid & ~bus.out_ready;
  assign flush_inc = flush & (occupancy != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (clr_cnt) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc && !(&stall_q)) stall_q <= stall_q + 1'b1;
      if (flush_inc && !(&flush_q)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule
